// File: rtl/frame_rr_arbiter_pkg.sv
// Shared types for the frame round-robin arbiter: FSM state encoding.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package frame_rr_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/frame_rr_arbiter_rr_priority_select.sv
// Round-robin winner search: first requester at or after last_grant+1, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is used.
module rr_priority_select #(
  parameter int NUM_INPUTS  = 2,
  parameter int GRANT_WIDTH = $clog2(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0]  i_req,
  input  logic [GRANT_WIDTH-1:0] i_last_grant,
  output logic [GRANT_WIDTH-1:0] o_winner,
  output logic                   o_found
);

  int w_dist;
  int w_best;

  // Pick the requester with the smallest rotational distance from last_grant+1.
  always_comb begin
    o_winner = '0;
    o_found  = 1'b0;
    w_best   = NUM_INPUTS;
    w_dist   = 0;
    for (int j = 0; j < NUM_INPUTS; j++) begin
      w_dist = (j + 2 * NUM_INPUTS - int'(i_last_grant) - 1) % NUM_INPUTS;
      if (i_req[j] && (w_dist < w_best)) begin
        w_best   = w_dist;
        o_winner = GRANT_WIDTH'(j);
        o_found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_rr_arbiter.sv
// Frame-level round-robin arbiter: N AXI-Stream inputs onto one output, whole frames only.
// Latency: data path combinational while granted; one IDLE cycle between frames for arbitration.
// Backpressure: m_axis_tready passes straight to the granted port; all other ports see tready=0.
module frame_rr_arbiter
  import frame_rr_arbiter_pkg::*;
#(
  parameter  int DATA_WIDTH  = 8,
  parameter  int NUM_INPUTS  = 2,
  localparam int KEEP_WIDTH  = DATA_WIDTH / 8,
  localparam int GRANT_WIDTH = $clog2(NUM_INPUTS)
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_INPUTS*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [NUM_INPUTS-1:0]            s_axis_tvalid,
  input  logic [NUM_INPUTS-1:0]            s_axis_tlast,
  output logic [NUM_INPUTS-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tlast,
  output logic                             grant_valid,
  output logic [GRANT_WIDTH-1:0]           grant_index
);

  arb_state_t             r_state;
  arb_state_t             w_state_nxt;
  logic [GRANT_WIDTH-1:0] r_grant_index;
  logic [GRANT_WIDTH-1:0] w_grant_nxt;
  logic [GRANT_WIDTH-1:0] r_last_grant;
  logic [GRANT_WIDTH-1:0] w_last_nxt;
  logic [GRANT_WIDTH-1:0] w_winner;
  logic                   w_found;
  logic                   w_busy;

  rr_priority_select #(
    .NUM_INPUTS  (NUM_INPUTS),
    .GRANT_WIDTH (GRANT_WIDTH)
  ) u_rr_priority_select (
    .i_req        (s_axis_tvalid),
    .i_last_grant (r_last_grant),
    .o_winner     (w_winner),
    .o_found      (w_found)
  );

  // Reset is folded into the output gate so nothing is forwarded while rstn is low,
  // even before the reset edge has cleared a BUSY state.
  assign w_busy      = (r_state == BUSY) && rstn;
  assign grant_valid = w_busy;
  assign grant_index = r_grant_index;

  // State and grant registers; reset abandons any partial frame.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state       <= IDLE;
      r_grant_index <= '0;
      r_last_grant  <= GRANT_WIDTH'(NUM_INPUTS - 1);
    end else begin
      r_state       <= w_state_nxt;
      r_grant_index <= w_grant_nxt;
      r_last_grant  <= w_last_nxt;
    end
  end

  // Output mux from the granted port, then next-state: grant in IDLE, release on the tlast handshake.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant_index;
    w_last_nxt    = r_last_grant;

    if (w_busy) begin
      m_axis_tdata                 = s_axis_tdata[int'(r_grant_index)*DATA_WIDTH +: DATA_WIDTH];
      m_axis_tkeep                 = s_axis_tkeep[int'(r_grant_index)*KEEP_WIDTH +: KEEP_WIDTH];
      m_axis_tvalid                = s_axis_tvalid[r_grant_index];
      m_axis_tlast                 = s_axis_tlast[r_grant_index];
      s_axis_tready[r_grant_index] = m_axis_tready;
    end

    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = BUSY;
          w_grant_nxt = w_winner;
        end
      end
      BUSY: begin
        if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
          w_state_nxt = IDLE;
          w_last_nxt  = r_grant_index;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule
